// File: rtl/xalu_ise_arb.sv
// Purpose : two-requester arbiter in front of one shared combinational ISE datapath, with registered per-requester response slots and completion counters.
// Latency : a request is granted in the cycle it is eligible; its response is valid in the following cycle.
// Backpress: a requester is granted only if its response slot is empty or drains in that cycle; a stalled slot holds its value.
// Build option: define XALU_ISE_ARB_RR_EN to get round-robin arbitration; by default requester 0 has fixed priority.
module xalu_ise_arb #(
   parameter int CNT_W = 16
) (
   input  logic             ise_clk,
   input  logic             ise_rst,
   // request channel 0
   input  logic             req0_val,
   output logic             req0_rdy,
   input  logic [5:0]       req0_fn,
   input  logic [6:0]       req0_imm,
   input  logic [31:0]      req0_in1,
   input  logic [31:0]      req0_in2,
   // request channel 1
   input  logic             req1_val,
   output logic             req1_rdy,
   input  logic [5:0]       req1_fn,
   input  logic [6:0]       req1_imm,
   input  logic [31:0]      req1_in1,
   input  logic [31:0]      req1_in2,
   // response channel 0
   output logic             rsp0_val,
   input  logic             rsp0_rdy,
   output logic [31:0]      rsp0_out,
   output logic             rsp0_err,
   // response channel 1
   output logic             rsp1_val,
   input  logic             rsp1_rdy,
   output logic [31:0]      rsp1_out,
   output logic             rsp1_err,
   // successful completion counters
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   // shared datapath
   output logic             dp_val,
   output logic [5:0]       dp_fn,
   output logic [6:0]       dp_imm,
   output logic [31:0]      dp_in1,
   output logic [31:0]      dp_in2,
   input  logic             dp_oval,
   input  logic [31:0]      dp_out
);

   logic elig0;
   logic elig1;
   logic gnt0;
   logic gnt1;

`ifdef XALU_ISE_ARB_RR_EN
   // 1 = requester 1 was granted last; reset value makes requester 0 win first
   logic last_gnt;
`endif

   // Eligibility and arbitration; nothing is granted while reset is held
   always_comb begin
      elig0 = ise_rst & req0_val & (~rsp0_val | rsp0_rdy);
      elig1 = ise_rst & req1_val & (~rsp1_val | rsp1_rdy);
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      if (elig0 && elig1) begin
`ifdef XALU_ISE_ARB_RR_EN
         gnt0 = last_gnt;
         gnt1 = ~last_gnt;
`else
         gnt0 = 1'b1;
`endif
      end else begin
         gnt0 = elig0;
         gnt1 = elig1;
      end
   end

   assign req0_rdy = gnt0;
   assign req1_rdy = gnt1;
   assign dp_val   = gnt0 | gnt1;

   // Datapath operand mux; operands are forced to zero when idle
   always_comb begin
      dp_fn  = '0;
      dp_imm = '0;
      dp_in1 = '0;
      dp_in2 = '0;
      if (gnt0) begin
         dp_fn  = req0_fn;
         dp_imm = req0_imm;
         dp_in1 = req0_in1;
         dp_in2 = req0_in2;
      end else if (gnt1) begin
         dp_fn  = req1_fn;
         dp_imm = req1_imm;
         dp_in1 = req1_in1;
         dp_in2 = req1_in2;
      end
   end

`ifdef XALU_ISE_ARB_RR_EN
   // Remember who won, only on cycles that actually grant
   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
         last_gnt <= 1'b1;
      end else if (gnt0 || gnt1) begin
         last_gnt <= gnt1;
      end
   end
`endif

   // Response slot 0: capture on grant (refill wins over drain), clear on drain
   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
         rsp0_val <= 1'b0;
         rsp0_out <= '0;
         rsp0_err <= 1'b0;
         cnt0     <= '0;
      end else if (gnt0) begin
         rsp0_val <= 1'b1;
         rsp0_out <= dp_oval ? dp_out : '0;
         rsp0_err <= ~dp_oval;
         if (dp_oval) begin
            cnt0 <= cnt0 + CNT_W'(1);
         end
      end else if (rsp0_rdy) begin
         rsp0_val <= 1'b0;
      end
   end

   // Response slot 1: capture on grant (refill wins over drain), clear on drain
   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
         rsp1_val <= 1'b0;
         rsp1_out <= '0;
         rsp1_err <= 1'b0;
         cnt1     <= '0;
      end else if (gnt1) begin
         rsp1_val <= 1'b1;
         rsp1_out <= dp_oval ? dp_out : '0;
         rsp1_err <= ~dp_oval;
         if (dp_oval) begin
            cnt1 <= cnt1 + CNT_W'(1);
         end
      end else if (rsp1_rdy) begin
         rsp1_val <= 1'b0;
      end
   end

endmodule

// File: tb/tb_xalu_ise_arb.sv
// Bench for xalu_ise_arb: directed opening cases, then random traffic.
// A reference model predicts grants and pushes expected responses into per-requester queues.
// A separate monitor pops and compares on every response handshake.
module tb_xalu_ise_arb;
   localparam int CNT_W = 3;

   logic             ise_clk = 1'b0;
   logic             ise_rst = 1'b0;
   logic             req0_val = 1'b0, req1_val = 1'b0;
   logic             req0_rdy, req1_rdy;
   logic [5:0]       req0_fn = '0, req1_fn = '0;
   logic [6:0]       req0_imm = '0, req1_imm = '0;
   logic [31:0]      req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
   logic             rsp0_val, rsp1_val;
   logic             rsp0_rdy = 1'b0, rsp1_rdy = 1'b0;
   logic [31:0]      rsp0_out, rsp1_out;
   logic             rsp0_err, rsp1_err;
   logic [CNT_W-1:0] cnt0, cnt1;
   logic             dp_val;
   logic [5:0]       dp_fn;
   logic [6:0]       dp_imm;
   logic [31:0]      dp_in1, dp_in2;
   logic             dp_oval;
   logic [31:0]      dp_out;

   always #5 ise_clk = ~ise_clk;

   // Behavioural grain datapath: fn 3F is illegal, fn 01 returns a marker
   function automatic logic dp_ok(logic [5:0] fn);
      return fn != 6'h3F;
   endfunction
   function automatic logic [31:0] dp_res(logic [5:0] fn, logic [6:0] imm, logic [31:0] a, logic [31:0] b);
      if (fn == 6'h01) return 32'hA5A5_0001;
      if (fn == 6'h3F) return 32'hFFFF_FFFF;
      return a + b + {25'd0, imm};
   endfunction
   assign dp_oval = dp_ok(dp_fn);
   assign dp_out  = dp_res(dp_fn, dp_imm, dp_in1, dp_in2);

   xalu_ise_arb #(.CNT_W(CNT_W)) dut (
      .ise_clk(ise_clk), .ise_rst(ise_rst),
      .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_fn(req0_fn), .req0_imm(req0_imm),
      .req0_in1(req0_in1), .req0_in2(req0_in2),
      .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_fn(req1_fn), .req1_imm(req1_imm),
      .req1_in1(req1_in1), .req1_in2(req1_in2),
      .rsp0_val(rsp0_val), .rsp0_rdy(rsp0_rdy), .rsp0_out(rsp0_out), .rsp0_err(rsp0_err),
      .rsp1_val(rsp1_val), .rsp1_rdy(rsp1_rdy), .rsp1_out(rsp1_out), .rsp1_err(rsp1_err),
      .cnt0(cnt0), .cnt1(cnt1),
      .dp_val(dp_val), .dp_fn(dp_fn), .dp_imm(dp_imm), .dp_in1(dp_in1), .dp_in2(dp_in2),
      .dp_oval(dp_oval), .dp_out(dp_out)
   );

   typedef struct packed {
      logic [31:0]      out;
      logic             err;
      logic [CNT_W-1:0] cnt;
   } rsp_t;

   rsp_t q0[$];
   rsp_t q1[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state: slot occupancy, last winner, completion counts
   bit               full_m[2];
   int               last_m;
   logic [CNT_W-1:0] cnt_m[2];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reset_model();
      full_m[0] = 0; full_m[1] = 0;
      last_m    = 1;
      cnt_m[0]  = '0; cnt_m[1] = '0;
      q0.delete(); q1.delete();
   endtask

   // Predict this cycle's grant from the driven inputs, compare, push expectation
   task automatic evaluate();
      bit   e0, e1, ok;
      int   g;
      rsp_t item;
      #1;
      e0 = ise_rst && req0_val && (!full_m[0] || rsp0_rdy);
      e1 = ise_rst && req1_val && (!full_m[1] || rsp1_rdy);
      g  = -1;
      if (e0 && e1) begin
`ifdef XALU_ISE_ARB_RR_EN
         g = (last_m == 0) ? 1 : 0;
`else
         g = 0;
`endif
      end else if (e0) g = 0;
      else if (e1) g = 1;
      check("req0_rdy", req0_rdy, g == 0);
      check("req1_rdy", req1_rdy, g == 1);
      check("dp_val", dp_val, g >= 0);
      check("dp_in1", dp_in1, g == 0 ? req0_in1 : (g == 1 ? req1_in1 : 32'd0));
      check("dp_fn", dp_fn, g == 0 ? req0_fn : (g == 1 ? req1_fn : 6'd0));
      if (g == 0) begin
         ok = dp_ok(req0_fn);
         if (ok) cnt_m[0] = cnt_m[0] + 1'b1;
         item.out = ok ? dp_res(req0_fn, req0_imm, req0_in1, req0_in2) : 32'd0;
         item.err = !ok;
         item.cnt = cnt_m[0];
         q0.push_back(item);
      end else if (g == 1) begin
         ok = dp_ok(req1_fn);
         if (ok) cnt_m[1] = cnt_m[1] + 1'b1;
         item.out = ok ? dp_res(req1_fn, req1_imm, req1_in1, req1_in2) : 32'd0;
         item.err = !ok;
         item.cnt = cnt_m[1];
         q1.push_back(item);
      end
      if (ise_rst) begin
         full_m[0] = (g == 0) ? 1 : (rsp0_rdy ? 0 : full_m[0]);
         full_m[1] = (g == 1) ? 1 : (rsp1_rdy ? 0 : full_m[1]);
         if (g >= 0) last_m = g;
      end
   endtask

   task automatic set_req(int n, bit v, logic [5:0] fn, logic [6:0] imm, logic [31:0] a, logic [31:0] b);
      if (n == 0) begin
         req0_val = v; req0_fn = fn; req0_imm = imm; req0_in1 = a; req0_in2 = b;
      end else begin
         req1_val = v; req1_fn = fn; req1_imm = imm; req1_in1 = a; req1_in2 = b;
      end
   endtask

   task automatic next_cycle();
      @(posedge ise_clk);
      #2;
   endtask

   // Monitor: a response slot must never be valid without an expectation;
   // each handshake pops and compares output, error flag and counter
   always @(negedge ise_clk) begin
      rsp_t e;
      check("rsp0_unexpected", rsp0_val && q0.size() == 0, 0);
      check("rsp1_unexpected", rsp1_val && q1.size() == 0, 0);
      if (rsp0_val && rsp0_rdy && q0.size() != 0) begin
         e = q0.pop_front();
         check("rsp0_out", rsp0_out, e.out);
         check("rsp0_err", rsp0_err, e.err);
         check("cnt0", cnt0, e.cnt);
      end
      if (rsp1_val && rsp1_rdy && q1.size() != 0) begin
         e = q1.pop_front();
         check("rsp1_out", rsp1_out, e.out);
         check("rsp1_err", rsp1_err, e.err);
         check("cnt1", cnt1, e.cnt);
      end
   end

   initial begin
      reset_model();
      #12;
      check("rst_rsp0_val", rsp0_val, 0);
      check("rst_rsp1_val", rsp1_val, 0);
      check("rst_rsp0_out", rsp0_out, 0);
      check("rst_rsp0_err", rsp0_err, 0);
      check("rst_cnt0", cnt0, 0);
      check("rst_cnt1", cnt1, 0);
      check("rst_dp_val", dp_val, 0);

      // Single request on 0 with the marker op, then an illegal op
      next_cycle();
      ise_rst = 1'b1;
      rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;
      set_req(0, 1, 6'h01, 7'h00, 32'h1234_5678, 32'h0);
      set_req(1, 0, 6'h00, 7'h00, 32'h0, 32'h0);
      evaluate();
      next_cycle();
      set_req(0, 1, 6'h3F, 7'h11, 32'h0BAD_0BAD, 32'h1);
      evaluate();
      // Both requesting continuously with sinks ready
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         set_req(0, 1, 6'h02, 7'(i), 32'h100 + 32'(i), 32'h5);
         set_req(1, 1, 6'h03, 7'(i), 32'h200 + 32'(i), 32'h7);
         evaluate();
      end
      // Stall slot 0 for three cycles while both request, then release
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         rsp0_rdy = (i == 3);
         set_req(0, 1, 6'h04, 7'h22, 32'h300 + 32'(i), 32'h9);
         set_req(1, 1, 6'h05, 7'h33, 32'h400 + 32'(i), 32'hB);
         evaluate();
      end
      // Requester 1 alone long enough to wrap the narrow counter
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;
         set_req(0, 0, 6'h00, 7'h00, 32'h0, 32'h0);
         set_req(1, 1, 6'h06, 7'(i), 32'(i * 3), 32'h1);
         evaluate();
      end

      // Random traffic with random backpressure
      for (int i = 0; i < 600; i++) begin
         next_cycle();
         rsp0_rdy = ($urandom_range(0, 9) < 6);
         rsp1_rdy = ($urandom_range(0, 9) < 6);
         for (int n = 0; n < 2; n++)
            set_req(n, $urandom_range(0, 9) < 7,
                    ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom),
                    7'($urandom), $urandom, $urandom);
         evaluate();
      end

      // Reset asserted between grant and response: the request is lost
      next_cycle();
      rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
      set_req(0, 1, 6'h07, 7'h01, 32'hCAFE_0000, 32'h1);
      set_req(1, 0, 6'h00, 7'h00, 32'h0, 32'h0);
      evaluate();
      #1 ise_rst = 1'b0;
      reset_model();
      #1;
      check("midrst_rsp0_val", rsp0_val, 0);
      check("midrst_cnt0", cnt0, 0);
      check("midrst_req0_rdy", req0_rdy, 0);
      check("midrst_dp_val", dp_val, 0);
      next_cycle();
      evaluate();
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         ise_rst = 1'b1;
         rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;
         set_req(0, 0, 6'h00, 7'h00, 32'h0, 32'h0);
         evaluate();
      end
      check("post_rst_rsp0_val", rsp0_val, 0);
      // First edge after release grants again
      next_cycle();
      set_req(0, 1, 6'h08, 7'h02, 32'h55, 32'h66);
      set_req(1, 1, 6'h09, 7'h03, 32'h77, 32'h88);
      evaluate();

      // Drain everything and confirm no expectation is left over
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         set_req(0, 0, 6'h00, 7'h00, 32'h0, 32'h0);
         set_req(1, 0, 6'h00, 7'h00, 32'h0, 32'h0);
         evaluate();
      end
      @(negedge ise_clk);
      #1;
      check("q0_leftover", q0.size(), 0);
      check("q1_leftover", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/xalu_ise_arb.md
XALU_ISE_ARB -- requirements
Module: xalu_ise_arb

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the per-requester completion counters.
REQ-002 SHALL have port ise_clk, input, 1: sole clock; all state on rising edge.
REQ-003 SHALL have port ise_rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports reqN_val in 1, reqN_rdy out 1, reqN_fn in 6, reqN_imm in 7, reqN_in1 in 32, reqN_in2 in 32, for N=0,1: request channel N.
REQ-005 SHALL have ports rspN_val out 1, rspN_rdy in 1, rspN_out out 32, rspN_err out 1, for N=0,1: response channel N.
REQ-006 SHALL have ports cntN out CNT_W, for N=0,1: count of successful completions for requester N.
REQ-007 SHALL have ports dp_val out 1, dp_fn out 6, dp_imm out 7, dp_in1 out 32, dp_in2 out 32: drive to the shared combinational grain ISE datapath.
REQ-008 SHALL have ports dp_oval in 1, dp_out in 32: same-cycle result and valid from the datapath.

Function
REQ-009 SHALL treat requester N as eligible when reqN_val=1 and the response slot is free (rspN_val=0, or rspN_val=1 with rspN_rdy=1 in the same cycle).
REQ-010 SHALL grant at most one eligible requester per cycle; reqN_rdy=1 only for the granted requester.
REQ-011 SHALL drive dp_val=1 and dp_fn/imm/in1/in2 from the granted requester in the grant cycle; with no grant, dp_val and all dp operands SHALL be 0.
REQ-012 SHALL, on the clock edge ending a grant to N, capture rspN_out=dp_out and rspN_err=0 if dp_oval=1, else rspN_out=0 and rspN_err=1; rspN_val=1 from the next cycle (latency 1).
REQ-013 SHALL hold rspN_val, rspN_out and rspN_err stable while rspN_val=1 and rspN_rdy=0.
REQ-014 SHALL clear rspN_val on an edge where rspN_rdy=1 and N is not granted; on drain plus grant in the same cycle, rspN_val SHALL stay 1 with the new result.
REQ-015 SHALL sustain one grant per cycle to a single requester when its rspN_rdy is held at 1.
REQ-016 SHALL increment cntN by 1 per capture with dp_oval=1, wrapping from 2^CNT_W-1 to 0; error captures SHALL NOT count.
REQ-017 SHALL keep a last-grant pointer updated only on grant edges; with both eligible, arbitration follows REQ-024/025.
REQ-018 SHALL handle a requester with reqN_val=1 but a full, undrained slot as ineligible; the other requester SHALL still be granted.

Reset
REQ-019 SHALL, while ise_rst=0, asynchronously force rspN_val=0, rspN_out=0, rspN_err=0, cntN=0 and last-grant pointer=1.
REQ-020 SHALL keep reqN_rdy=0 and dp_val=0 while ise_rst=0.
REQ-021 SHALL discard an in-flight response when reset asserts mid-operation; the request is lost and SHALL NOT be replayed.
REQ-022 SHALL grant again on the first rising edge after ise_rst deasserts.

Configuration
REQ-023 SHALL use macro XALU_ISE_ARB_RR_EN.
REQ-024 SHALL, with XALU_ISE_ARB_RR_EN defined, grant the requester not last granted when both are eligible (round-robin; requester 0 first after reset).
REQ-025 SHALL, without XALU_ISE_ARB_RR_EN, always grant requester 0 when both are eligible (fixed priority); the pointer MAY be omitted.

Verification
REQ-026 SHALL cover: req0 only, fn=6'h01, imm=7'h00, in1=32'h1234_5678; model dp_oval=1, dp_out=32'hA5A5_0001 -> req0_rdy=1 that cycle; next cycle rsp0_val=1, rsp0_out=32'hA5A5_0001, rsp0_err=0, cnt0=1.
REQ-027 SHALL cover: both requesting continuously, rsp rdy=1, RR_EN defined -> grants 0,1,0,1 over 4 cycles; RR_EN undefined -> grants 0,0,0,0 and cnt1=0.
REQ-028 SHALL cover: rsp0_rdy=0 for 3 cycles after the first result -> rsp0_out stable, req0_rdy=0, req1 granted meanwhile; rsp0_rdy=1 -> req0 granted the same cycle.
REQ-029 SHALL cover: illegal op with model dp_oval=0, dp_out=32'hFFFF_FFFF -> rsp0_out=0, rsp0_err=1, cnt0 unchanged.
REQ-030 SHALL cover: CNT_W=2 with 5 successful ops on req1 -> cnt1 sequence 1,2,3,0,1.
REQ-031 SHALL cover: ise_rst=0 asserted between grant and response -> rsp0_val=0 immediately, cnt0=0, no response after release.
